mem_sweep_engine: RTL and testbench

- Parametrised successor of the single-shot memory write FSM.
- Owns an on-chip RAM of 2^ADDR_W words × DATA_W bits and runs one command per start pulse:
  - FILL: write an incrementing pattern.
  - CLEAR: write zeros.
  - CHECK: read back and compare against the pattern.
- Sweeps a programmable start address and length, with wrap-around.
- Exposes an end pulse, an error count and the debug taps used by the memory testbenches.

---
 rtl/mem_sweep_pkg.sv | 26 ++
 rtl/sweep_ram.sv | 43 ++++
 rtl/mem_sweep_engine.sv | 163 ++++++++++++++++
 tb/tb_mem_sweep_engine.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_sweep_pkg.sv
// Shared types for the memory sweep engine.
//   state_t : FSM state; the encoding is exported on fsm_tb.
//   mode_t  : command selector sampled at capture.
//   depth_of: word count of a RAM with the given address width.
package mem_sweep_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_WRITE = 3'b001,
        ST_READ  = 3'b010,
        ST_CMP   = 3'b011,
        ST_DONE  = 3'b100
    } state_t;

    typedef enum logic [1:0] {
        MODE_FILL  = 2'b00,
        MODE_CHECK = 2'b01,
        MODE_CLEAR = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_t;

    function automatic int unsigned depth_of(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

endpackage

// File: rtl/sweep_ram.sv
// Simple dual-port RAM, 2^ADDR_W x DATA_W.
//   clk, rst     : clock, async active-low reset (output registers only)
//   we, a_add,
//   a_wdata      : port A write
//   a_rdata      : port A registered read of a_add (used by CHECK)
//   b_add,
//   b_rdata      : port B registered read (debug tap)
// The array itself is never reset, so contents survive an engine reset.
module sweep_ram
    import mem_sweep_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] a_add,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    input  logic [ADDR_W-1:0] b_add,
    output logic [DATA_W-1:0] b_rdata
);

    localparam int unsigned DEPTH = depth_of(ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[a_add] <= a_wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_rdata <= '0;
            b_rdata <= '0;
        end else begin
            a_rdata <= mem[a_add];
            b_rdata <= mem[b_add];
        end
    end

endmodule

// File: rtl/mem_sweep_engine.sv
// Memory sweep engine: one FILL / CHECK / CLEAR command per enable pulse
// over a programmable, wrapping address window of an on-chip RAM.
//   clk, rst          : clock, async active-low reset
//   enable, mode,
//   start_add, len,
//   pat_base          : command, captured in IDLE
//   busy, st_end      : activity flag, one-cycle completion pulse
//   cmd_err           : reserved mode seen on the last command
//   err_count,
//   first_err_add     : CHECK results
//   add_tb, write_tb,
//   fsm_tb            : debug taps (sweep address, last write, state)
//   dbg_rd_add,
//   dbg_rd_data       : debug read port, one-cycle latency
module mem_sweep_engine
    import mem_sweep_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] start_add,
    input  logic [CNT_W-1:0]  len,
    input  logic [DATA_W-1:0] pat_base,
    output logic              busy,
    output logic              st_end,
    output logic              cmd_err,
    output logic [CNT_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_add,
    output logic [ADDR_W-1:0] add_tb,
    output logic [DATA_W-1:0] write_tb,
    output logic [2:0]        fsm_tb,
    input  logic [ADDR_W-1:0] dbg_rd_add,
    output logic [DATA_W-1:0] dbg_rd_data
);

    state_t            state;
    mode_t             mode_q;
    logic [ADDR_W-1:0] start_q;
    logic [CNT_W-1:0]  len_q;
    logic [DATA_W-1:0] pat_q;
    logic [CNT_W-1:0]  ofs;

    logic [ADDR_W-1:0] cur_add;
    logic [DATA_W-1:0] cur_pat;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_we;
    logic              sweep_done;

    // Address and pattern both wrap naturally by truncation.
    assign cur_add    = start_q + ofs[ADDR_W-1:0];
    assign cur_pat    = pat_q + DATA_W'(ofs);
    assign wr_data    = (mode_q == MODE_CLEAR) ? '0 : cur_pat;
    // WRITE/READ spend one extra visit with ofs == len_q to close the sweep.
    assign sweep_done = (ofs == len_q);
    assign ram_we     = (state == ST_WRITE) && !sweep_done;
    assign fsm_tb     = state;

    sweep_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we      (ram_we),
        .a_add   (cur_add),
        .a_wdata (wr_data),
        .a_rdata (ram_rdata),
        .b_add   (dbg_rd_add),
        .b_rdata (dbg_rd_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            mode_q        <= MODE_FILL;
            start_q       <= '0;
            len_q         <= '0;
            pat_q         <= '0;
            ofs           <= '0;
            busy          <= 1'b0;
            st_end        <= 1'b0;
            cmd_err       <= 1'b0;
            err_count     <= '0;
            first_err_add <= '0;
            add_tb        <= '0;
            write_tb      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        mode_q        <= mode_t'(mode);
                        start_q       <= start_add;
                        len_q         <= len;
                        pat_q         <= pat_base;
                        ofs           <= '0;
                        err_count     <= '0;
                        first_err_add <= '0;
                        cmd_err       <= 1'b0;
                        busy          <= 1'b1;
                        if (mode_t'(mode) == MODE_RSVD) begin
                            cmd_err <= 1'b1;
                            st_end  <= 1'b1;
                            state   <= ST_DONE;
                        end else if (len == '0) begin
                            st_end <= 1'b1;
                            state  <= ST_DONE;
                        end else if (mode_t'(mode) == MODE_CHECK) begin
                            state <= ST_READ;
                        end else begin
                            state <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (sweep_done) begin
                        st_end <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        add_tb   <= cur_add;
                        write_tb <= wr_data;
                        ofs      <= ofs + CNT_W'(1);
                    end
                end
                ST_READ: begin
                    if (sweep_done) begin
                        st_end <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        // RAM latches mem[cur_add] on this edge; ofs holds into CMP.
                        add_tb <= cur_add;
                        state  <= ST_CMP;
                    end
                end
                ST_CMP: begin
                    if (ram_rdata != cur_pat) begin
                        if (err_count != '1) err_count <= err_count + CNT_W'(1);
                        // A zero count can only mean no earlier mismatch this command.
                        if (err_count == '0) first_err_add <= cur_add;
                    end
                    ofs   <= ofs + CNT_W'(1);
                    state <= ST_READ;
                end
                ST_DONE: begin
                    st_end <= 1'b0;
                    busy   <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    st_end <= 1'b0;
                    busy   <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_sweep_engine.sv
// Bench for mem_sweep_engine: directed vector table, hand-written corner
// sequences (busy-ignore, mid-command reset) and randomized commands checked
// against a word-array reference model.
module tb_mem_sweep_engine;

    localparam int LIMIT = 1000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] start_add = '0;
    logic [8:0] len = '0;
    logic [7:0] pat_base = '0;
    logic       busy, st_end, cmd_err;
    logic [8:0] err_count;
    logic [7:0] first_err_add, add_tb, write_tb, dbg_rd_data;
    logic [2:0] fsm_tb;
    logic [7:0] dbg_rd_add = '0;

    always #5 clk = ~clk;

    mem_sweep_engine dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .mode          (mode),
        .start_add     (start_add),
        .len           (len),
        .pat_base      (pat_base),
        .busy          (busy),
        .st_end        (st_end),
        .cmd_err       (cmd_err),
        .err_count     (err_count),
        .first_err_add (first_err_add),
        .add_tb        (add_tb),
        .write_tb      (write_tb),
        .fsm_tb        (fsm_tb),
        .dbg_rd_add    (dbg_rd_add),
        .dbg_rd_data   (dbg_rd_data)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: RAM image plus expected results of the last command.
    int ref_mem [256];
    int m_lat, m_err, m_first, m_cerr, m_add, m_wr;

    typedef struct {
        int md, st, ln, pt;
        int lat, err, first, cerr, add, wr;
    } vec_t;
    vec_t tbl [9];

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Command semantics: offset i in 0..len-1, address (start+i) mod 256,
    // pattern (pat+i) mod 256. Latency counts edges after capture until st_end.
    task automatic model_cmd(input int md, input int st, input int ln, input int pt);
        int a, p;
        m_err = 0; m_first = 0; m_cerr = 0; m_lat = 0;
        if (md == 3) begin
            m_cerr = 1;
        end else if (ln != 0) begin
            for (int i = 0; i < ln; i++) begin
                a = (st + i) % 256;
                p = (pt + i) % 256;
                if (md == 1) begin
                    if (ref_mem[a] != p) begin
                        if (m_err == 0) m_first = a;
                        m_err++;
                    end
                end else begin
                    ref_mem[a] = (md == 0) ? p : 0;
                    m_wr = ref_mem[a];
                end
                m_add = a;
            end
            m_lat = (md == 1) ? 2 * ln + 1 : ln + 1;
        end
    endtask

    task automatic do_cmd(input int md, input int st, input int ln, input int pt,
                          output int lat, output int cerr_end);
        @(negedge clk);
        mode = md[1:0]; start_add = st[7:0]; len = ln[8:0]; pat_base = pt[7:0];
        enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        lat = 0;
        while (!st_end && lat < LIMIT) begin
            @(posedge clk); #1;
            lat++;
        end
        cerr_end = cmd_err;
        @(posedge clk); #1;
        chk("st_end_single", st_end, 0);
        chk("idle_after", {busy, fsm_tb}, 0);
    endtask

    task automatic dbg_read(input int a, output int d);
        @(negedge clk);
        dbg_rd_add = a[7:0];
        @(posedge clk); #1;
        d = dbg_rd_data;
    endtask

    task automatic chk_outputs(input string tag, input int lat, input int cerr_end,
                               input int e_lat, input int e_err, input int e_first,
                               input int e_cerr, input int e_add, input int e_wr);
        chk({tag, "_lat"}, lat, e_lat);
        chk({tag, "_err"}, err_count, e_err);
        chk({tag, "_first"}, first_err_add, e_first);
        chk({tag, "_cmd_err"}, cerr_end, e_cerr);
        chk({tag, "_cmd_err_hold"}, cmd_err, e_cerr);
        chk({tag, "_add_tb"}, add_tb, e_add);
        chk({tag, "_write_tb"}, write_tb, e_wr);
    endtask

    initial begin
        int lat, ce, d, cnt, md, st, ln, pt, r;
        int lf_st, lf_ln, lf_pt;

        // ---- reset state ----
        #22;
        chk("rst_outputs", {busy, st_end, cmd_err, err_count, first_err_add,
                            add_tb, write_tb, dbg_rd_data}, 0);
        chk("rst_fsm", fsm_tb, 0);
        @(negedge clk); rst = 1'b1;

        // ---- full-depth CLEAR gives the model a known image ----
        for (int i = 0; i < 256; i++) ref_mem[i] = 0;
        m_add = 0; m_wr = 0;
        do_cmd(2, 0, 256, 0, lat, ce);
        model_cmd(2, 0, 256, 0);
        chk_outputs("clear_all", lat, ce, 257, 0, 0, 0, 'hFF, 0);

        // ---- directed vector table ----
        tbl[0] = '{0, 'h10, 4, 'hA0, 5, 0, 0,     0, 'h13, 'hA3};
        tbl[1] = '{1, 'h10, 4, 'hA0, 9, 0, 0,     0, 'h13, 'hA3};
        tbl[2] = '{1, 'h10, 4, 'hA1, 9, 4, 'h10,  0, 'h13, 'hA3};
        tbl[3] = '{0, 'hFE, 4, 'h00, 5, 0, 0,     0, 'h01, 'h03};
        tbl[4] = '{0, 'h20, 0, 'h55, 0, 0, 0,     0, 'h01, 'h03};
        tbl[5] = '{3, 'h30, 5, 'h77, 0, 0, 0,     1, 'h01, 'h03};
        tbl[6] = '{1, 'hFE, 4, 'h00, 9, 0, 0,     0, 'h01, 'h03};
        tbl[7] = '{2, 'h11, 2, 'h99, 3, 0, 0,     0, 'h12, 'h00};
        tbl[8] = '{1, 'h10, 4, 'hA0, 9, 2, 'h11,  0, 'h13, 'h00};
        for (int v = 0; v < 9; v++) begin
            do_cmd(tbl[v].md, tbl[v].st, tbl[v].ln, tbl[v].pt, lat, ce);
            model_cmd(tbl[v].md, tbl[v].st, tbl[v].ln, tbl[v].pt);
            chk_outputs($sformatf("vec%0d", v), lat, ce, tbl[v].lat, tbl[v].err,
                        tbl[v].first, tbl[v].cerr, tbl[v].add, tbl[v].wr);
        end
        // RAM image after the table: window, wrap and len=0 target.
        dbg_read('h10, d); chk("dbg_10", d, 'hA0);
        dbg_read('h13, d); chk("dbg_13", d, 'hA3);
        dbg_read('h11, d); chk("dbg_11", d, 'h00);
        dbg_read('hFE, d); chk("dbg_FE", d, 'h00);
        dbg_read('hFF, d); chk("dbg_FF", d, 'h01);
        dbg_read('h00, d); chk("dbg_00", d, 'h02);
        dbg_read('h01, d); chk("dbg_01", d, 'h03);
        dbg_read('h20, d); chk("dbg_20_len0", d, 'h00);

        // ---- enable pulsed while busy must be ignored ----
        @(negedge clk);
        mode = 2'b00; start_add = 8'h80; len = 9'd6; pat_base = 8'h10; enable = 1'b1;
        @(posedge clk); #1; enable = 1'b0;
        cnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mode = 2'b10; start_add = 8'h80; len = 9'd6; enable = 1'b1;
        @(posedge clk); #1; enable = 1'b0;
        if (st_end) cnt++;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (st_end) cnt++;
        end
        chk("busy_ignore_st_end_count", cnt, 1);
        model_cmd(0, 'h80, 6, 'h10);
        dbg_read('h80, d); chk("busy_ignore_80", d, ref_mem['h80]);
        dbg_read('h85, d); chk("busy_ignore_85", d, ref_mem['h85]);
        chk("busy_ignore_write_tb", write_tb, 'h15);

        // ---- reset after 2 of 8 FILL words ----
        @(negedge clk);
        mode = 2'b00; start_add = 8'h40; len = 9'd8; pat_base = 8'h50; enable = 1'b1;
        @(posedge clk); #1; enable = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_outputs", {busy, st_end, cmd_err, err_count, first_err_add,
                               add_tb, write_tb, dbg_rd_data}, 0);
        chk("midrst_fsm", fsm_tb, 0);
        ref_mem['h40] = 'h50; ref_mem['h41] = 'h51;
        m_add = 0; m_wr = 0;
        @(negedge clk); rst = 1'b1;
        dbg_read('h40, d); chk("midrst_40", d, 'h50);
        dbg_read('h41, d); chk("midrst_41", d, 'h51);
        dbg_read('h42, d); chk("midrst_42", d, 'h00);
        dbg_read('h47, d); chk("midrst_47", d, 'h00);
        do_cmd(0, 'h40, 8, 'h60, lat, ce);
        model_cmd(0, 'h40, 8, 'h60);
        chk_outputs("post_rst_fill", lat, ce, m_lat, m_err, m_first, m_cerr, m_add, m_wr);
        dbg_read('h47, d); chk("post_rst_47", d, 'h67);

        // ---- randomized commands against the model ----
        lf_st = 'h40; lf_ln = 8; lf_pt = 'h60;
        for (int k = 0; k < 40; k++) begin
            r  = $urandom_range(0, 9);
            md = (r < 4) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : 3;
            st = $urandom_range(0, 255);
            ln = ($urandom_range(0, 9) == 0) ? 256 : $urandom_range(0, 15);
            pt = $urandom_range(0, 255);
            if (md == 1 && $urandom_range(0, 1) == 1) begin
                st = lf_st; ln = lf_ln; pt = lf_pt;
            end
            if (md == 0) begin lf_st = st; lf_ln = ln; lf_pt = pt; end
            do_cmd(md, st, ln, pt, lat, ce);
            model_cmd(md, st, ln, pt);
            chk_outputs($sformatf("rnd%0d", k), lat, ce, m_lat, m_err, m_first,
                        m_cerr, m_add, m_wr);
        end
        for (int k = 0; k < 16; k++) begin
            st = $urandom_range(0, 255);
            dbg_read(st, d);
            chk($sformatf("rnd_dbg_%0h", st), d, ref_mem[st]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
